// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fetch_pkg                                                    |
// | Description : Shared types and default geometry for the icache refill      |
// |               controller (refill FSM states, beat/offset sizes).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  // Default geometry; the top recomputes these from its own parameters.
  localparam int unsigned NUM_BEATS   = 512 / 64;
  localparam int unsigned BEAT_CNT_W  = $clog2(NUM_BEATS);
  localparam int unsigned BLOCK_BYTES = 512 / 8;
  localparam int unsigned OFFSET_W    = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_refill_ctrl_refill_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : refill_buffer                                                |
// | Description : Block assembly register. Each write deposits one beat at     |
// |               slice [idx*BEAT_WIDTH +: BEAT_WIDTH]; cleared on reset.      |
// | Ports       : i_clk, i_arst      - clock, async active-high reset          |
// |               i_wr_en            - write one beat this cycle               |
// |               i_wr_idx           - beat slot to write                      |
// |               i_wr_data          - beat payload                            |
// |               o_block            - assembled block                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module refill_buffer #(
  parameter int unsigned BLOCK_WIDTH = 512,
  parameter int unsigned BEAT_WIDTH  = 64,
  parameter int unsigned IDX_W       = 3
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_wr_en,
  input  logic [IDX_W-1:0]       i_wr_idx,
  input  logic [BEAT_WIDTH-1:0]  i_wr_data,
  output logic [BLOCK_WIDTH-1:0] o_block
);

  localparam int unsigned NUM_BEATS = BLOCK_WIDTH / BEAT_WIDTH;

  logic [BLOCK_WIDTH-1:0] block_d;
  logic [BLOCK_WIDTH-1:0] block_q;

  // One decoded enable per slot keeps the write a constant part-select.
  for (genvar i = 0; i < NUM_BEATS; i++) begin : g_beat
    assign block_d[i*BEAT_WIDTH +: BEAT_WIDTH] =
      (i_wr_en && (i_wr_idx == IDX_W'(i))) ? i_wr_data
                                           : block_q[i*BEAT_WIDTH +: BEAT_WIDTH];
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      block_q <= '0;
    end else begin
      block_q <= block_d;
    end
  end

  assign o_block = block_q;

endmodule
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : icache_refill_ctrl                                           |
// | Description : Icache miss handler. Stalls fetch on a miss, issues one      |
// |               block-aligned read, gathers NUM_BEATS beats and pulses the   |
// |               icache write enable with the assembled block.                |
// | Ports       : i_clk, i_arst       - clock, async active-high reset         |
// |               i_pc, i_icache_hit  - lookup address and its hit flag        |
// |               o_stall_fetch       - hold the PC register                   |
// |               o_mem_req_*         - block read request (valid/ready/addr)  |
// |               i_mem_resp_*        - response beats (always accepted)       |
// |               o_instr_we/_block   - icache block write                     |
// |               o_busy              - refill in progress                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module icache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned BLOCK_WIDTH = 512,
  parameter int unsigned BEAT_WIDTH  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic                   i_icache_hit,
  output logic                   o_stall_fetch,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  input  logic                   i_mem_resp_valid,
  input  logic [BEAT_WIDTH-1:0]  i_mem_resp_data,
  output logic                   o_instr_we,
  output logic [BLOCK_WIDTH-1:0] o_instr_block,
  output logic                   o_busy
);

  import fetch_pkg::*;

  localparam int unsigned NBEATS = BLOCK_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned BYTES  = BLOCK_WIDTH / 8;

  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BYTES - 1);

  refill_state_t           state_d, state_q;
  logic [ADDR_WIDTH-1:0]   addr_d,  addr_q;
  logic [CNT_W-1:0]        cnt_d,   cnt_q;
  logic                    w_beat_we;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    w_beat_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!i_icache_hit) begin
          addr_d  = i_pc & ~OFF_MASK;
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_mem_req_ready) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (i_mem_resp_valid) begin
          w_beat_we = 1'b1;
          // The beat count alone ends the burst; the counter is parked at
          // zero instead of wrapping.
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  refill_buffer #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .BEAT_WIDTH  (BEAT_WIDTH),
    .IDX_W       (CNT_W)
  ) u_refill_buffer (
    .i_clk     (i_clk),
    .i_arst    (i_arst),
    .i_wr_en   (w_beat_we),
    .i_wr_idx  (cnt_q),
    .i_wr_data (i_mem_resp_data),
    .o_block   (o_instr_block)
  );

  assign o_mem_req_valid = (state_q == REQ);
  assign o_mem_req_addr  = addr_q;
  assign o_instr_we      = (state_q == WRITE);
  assign o_busy          = (state_q != IDLE);
  // Stall must rise in the miss cycle itself, hence the live hit term.
  assign o_stall_fetch   = (state_q != IDLE) | ~i_icache_hit;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_icache_refill_ctrl                                        |
// | Description : Self-checking bench for icache_refill_ctrl. A transaction-   |
// |               level model (resident block tag, expected block assembled    |
// |               from driven beats, expected stall count) checks each refill. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         arst;
  logic [63:0]  pc;
  logic         hit;
  logic         stall;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_addr;
  logic         resp_valid;
  logic [63:0]  resp_data;
  logic         we;
  logic [511:0] blk;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of icache contents: one resident block tag.
  logic         res_valid = 1'b0;
  logic [57:0]  res_tag   = '0;
  logic [511:0] blk_model = '0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(
    .ADDR_WIDTH  (64),
    .BLOCK_WIDTH (512),
    .BEAT_WIDTH  (64)
  ) dut (
    .i_clk            (clk),
    .i_arst           (arst),
    .i_pc             (pc),
    .i_icache_hit     (hit),
    .o_stall_fetch    (stall),
    .o_mem_req_valid  (req_valid),
    .i_mem_req_ready  (req_ready),
    .o_mem_req_addr   (req_addr),
    .i_mem_resp_valid (resp_valid),
    .i_mem_resp_data  (resp_data),
    .o_instr_we       (we),
    .o_instr_block    (blk),
    .o_busy           (busy)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic model_hit(input logic [63:0] a);
    return res_valid && (a[63:6] == res_tag);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Idle cycle in which the given PC misses (cycle 0 of a refill).
  task automatic start_miss(input logic [63:0] a);
    next_cycle();
    pc         = a;
    hit        = model_hit(a);
    req_ready  = 1'($urandom_range(0, 1));
    resp_valid = 1'($urandom_range(0, 1));
    resp_data  = rand64();
    #1;
    check("miss_stall", stall, 1'b1);
    check("miss_busy", busy, 1'b0);
    check("miss_req_valid", req_valid, 1'b0);
    check("idle_block_kept", blk, blk_model);
  endtask

  // Runs cycles 1.. of a refill whose miss cycle has just been sampled.
  task automatic do_refill(input logic [63:0] a, input int wait_n, input int gap_n,
                           input bit rnd_gap, input bit seq_data, input logic [63:0] pc_after);
    logic [511:0] exp_blk;
    logic [63:0]  exp_addr;
    logic [63:0]  beat;
    int           stalls;
    int           gaps;
    int           g;
    logic         hv;
    exp_blk  = '0;
    exp_addr = a & ~64'h3F;
    stalls   = 0;
    gaps     = 0;
    for (int w = 0; w <= wait_n; w++) begin
      next_cycle();
      req_ready  = (w == wait_n);
      resp_valid = 1'($urandom_range(0, 1));
      resp_data  = rand64();
      hit        = 1'($urandom_range(0, 1));
      #1;
      check("req_valid", req_valid, 1'b1);
      check("req_addr", req_addr, exp_addr);
      check("req_busy", busy, 1'b1);
      if (stall) stalls++;
    end
    for (int k = 0; k < 8; k++) begin
      g = (k == 0) ? 0 : (rnd_gap ? $urandom_range(0, gap_n) : gap_n);
      if (k == 4) pc = pc_after;  // redirect mid-refill must not abort it
      for (int j = 0; j < g; j++) begin
        next_cycle();
        req_ready  = 1'($urandom_range(0, 1));
        resp_valid = 1'b0;
        resp_data  = rand64();
        hit        = 1'($urandom_range(0, 1));
        #1;
        check("gap_we", we, 1'b0);
        check("gap_req_valid", req_valid, 1'b0);
        check("gap_busy", busy, 1'b1);
        if (stall) stalls++;
        gaps++;
      end
      next_cycle();
      req_ready  = 1'($urandom_range(0, 1));
      beat       = seq_data ? 64'(k) : rand64();
      resp_valid = 1'b1;
      resp_data  = beat;
      hit        = 1'($urandom_range(0, 1));
      exp_blk[k*64 +: 64] = beat;
      #1;
      check("fill_we", we, 1'b0);
      check("fill_req_valid", req_valid, 1'b0);
      check("fill_busy", busy, 1'b1);
      if (stall) stalls++;
    end
    // Write cycle, with a stray response that must be ignored.
    next_cycle();
    resp_valid = 1'($urandom_range(0, 1));
    resp_data  = rand64();
    hit        = 1'($urandom_range(0, 1));
    #1;
    check("write_we", we, 1'b1);
    check("write_block", blk, exp_blk);
    check("write_busy", busy, 1'b1);
    if (stall) stalls++;
    res_valid = 1'b1;
    res_tag   = a[63:6];
    blk_model = exp_blk;
    // Back in idle: retried lookup of the (possibly redirected) PC.
    next_cycle();
    pc         = pc_after;
    hv         = model_hit(pc_after);
    hit        = hv;
    resp_valid = 1'($urandom_range(0, 1));
    resp_data  = rand64();
    #1;
    check("post_we", we, 1'b0);
    check("post_busy", busy, 1'b0);
    check("post_block", blk, exp_blk);
    check("post_stall", stall, !hv);
    check("stall_cycles", 32'(stalls), 32'(10 + wait_n + gaps));
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] pa;
    bit          redirect;
    bit          in_miss;

    arst       = 1'b1;
    pc         = '0;
    hit        = 1'b1;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    next_cycle();
    next_cycle();
    check("rst_stall", stall, 1'b0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_req_addr", req_addr, 64'h0);
    check("rst_we", we, 1'b0);
    check("rst_block", blk, 512'h0);
    check("rst_busy", busy, 1'b0);
    hit = 1'b0;
    #1;
    check("rst_stall_miss", stall, 1'b1);

    // Reset release straight into a miss at 0x1000.
    next_cycle();
    arst = 1'b0;
    pc   = 64'h1000;
    hit  = 1'b0;
    #1;
    check("c0_stall", stall, 1'b1);
    do_refill(64'h1000, 0, 0, 1'b0, 1'b0, 64'h1000);

    // Unaligned PC, three cycles of back-pressure.
    start_miss(64'h8000_0034);
    do_refill(64'h8000_0034, 3, 0, 1'b0, 1'b0, 64'h8000_0034);

    // Sequential beats with two-cycle gaps.
    start_miss(64'h0000_0000_0002_0000);
    do_refill(64'h0000_0000_0002_0000, 0, 2, 1'b0, 1'b1, 64'h0000_0000_0002_0000);

    // Randomized refills, some redirected mid-fill.
    in_miss = 1'b0;
    a       = rand64();
    for (int it = 0; it < 20; it++) begin
      if (!in_miss) begin
        a = rand64();
        if (model_hit(a)) a[6] = ~a[6];
        start_miss(a);
      end
      redirect = (it != 19) && ($urandom_range(0, 2) == 0);
      pa = a;
      if (redirect) begin
        pa = rand64();
        if (pa[63:6] == a[63:6]) pa[6] = ~pa[6];
      end
      do_refill(a, $urandom_range(0, 4), 3, 1'b1, 1'b0, pa);
      a       = pa;
      in_miss = redirect;
    end

    // Reset in the middle of FILL after four beats.
    start_miss(64'h0000_0000_4000_0010);
    next_cycle();
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    #1;
    check("rstfill_req_valid", req_valid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      resp_data  = rand64();
      #1;
      check("rstfill_busy", busy, 1'b1);
    end
    next_cycle();
    hit  = 1'b1;
    arst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_req_valid", req_valid, 1'b0);
    check("abort_we", we, 1'b0);
    check("abort_block", blk, 512'h0);
    check("abort_addr", req_addr, 64'h0);
    check("abort_stall", stall, 1'b0);
    next_cycle();
    arst       = 1'b0;
    resp_valid = 1'b0;
    res_valid  = 1'b0;
    blk_model  = '0;

    // Continuous hits: controller stays quiet.
    for (int c = 0; c < 100; c++) begin
      next_cycle();
      hit        = 1'b1;
      pc         = rand64();
      req_ready  = 1'($urandom_range(0, 1));
      resp_valid = 1'($urandom_range(0, 1));
      resp_data  = rand64();
      #1;
      check("hit_stall", stall, 1'b0);
      check("hit_req_valid", req_valid, 1'b0);
      check("hit_we", we, 1'b0);
      check("hit_busy", busy, 1'b0);
    end
    check("hit_block", blk, 512'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
